// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative shift controller.
// The early-exit variant is enabled with the ITER_SHIFT_EARLY_EXIT_EN macro.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  localparam int DEFAULT_WIDTH = 32;
  localparam int SHAMT_W       = $clog2(DEFAULT_WIDTH);
  localparam int NSTAGE        = SHAMT_W;

  // Width of a counter that indexes nstage stages (at least one bit).
  function automatic int stage_idx_w(input int nstage);
    return (nstage > 1) ? $clog2(nstage) : 1;
  endfunction

endpackage

// File: rtl/shift_stage_mux.sv
// One reusable shift stage: shifts by WIDTH/2 >> stage, or passes the value
// through when disabled. Built as a mux of constant shifts, not a barrel shifter.
module shift_stage_mux
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STG_W = stage_idx_w($clog2(DEFAULT_WIDTH))
) (
  input  logic [WIDTH-1:0] value,
  input  logic [STG_W-1:0] stage,
  input  logic             op,
  input  logic             enable,
  output logic [WIDTH-1:0] result
);

  localparam int NS = $clog2(WIDTH);

  // A separate signed view keeps >>> arithmetic; mixing it into an unsigned
  // expression would silently turn it into a logical shift.
  logic signed [WIDTH-1:0] value_s;
  assign value_s = value;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    result = value;
    if (enable) begin
      for (int i = 0; i < NS; i++) begin
        if (int'(stage) == i) begin
          if (op == OP_SRA) result = value_s >>> (WIDTH / 2 >> i);
          else              result = value << (WIDTH / 2 >> i);
        end
      end
    end
  end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle SLL/SRA controller driving one shared shift stage through amounts
// WIDTH/2 .. 1. Define ITER_SHIFT_EARLY_EXIT_EN to finish once no amount bits remain.
module iter_shift_ctrl
  import shift_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_shift,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [SW-1:0]    ctrl_shiftamt,
  input  logic             ctrl_op,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int             NS         = SW;
  localparam int             STG_W      = stage_idx_w(NS);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NS - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] result_nxt, stage_out;
  logic [SW-1:0]    amt, amt_nxt;
  logic             op, op_nxt;
  logic [STG_W-1:0] stage, stage_nxt;
  logic [SW-1:0]    bit_pos;
  logic             bit_set;
  logic             finish_shift;
  logic             start_done;

  // Stage 0 consumes the MSB of the amount, the last stage consumes bit 0.
  assign bit_pos = SW'(1) << (SW - 1 - int'(stage));
  assign bit_set = |(amt & bit_pos);

`ifdef ITER_SHIFT_EARLY_EXIT_EN
  logic lower_zero;
  assign lower_zero   = ((amt & (bit_pos - SW'(1))) == '0);
  assign finish_shift = (stage == LAST_STAGE) || lower_zero;
  assign start_done   = (ctrl_shiftamt == '0);
`else
  assign finish_shift = (stage == LAST_STAGE);
  assign start_done   = 1'b0;
`endif

  shift_stage_mux #(
    .WIDTH (WIDTH),
    .STG_W (STG_W)
  ) u_stage (
    .value  (data_result),
    .stage  (stage),
    .op     (op),
    .enable ((state == SHIFT) && bit_set),
    .result (stage_out)
  );

  always_comb begin
    state_nxt  = state;
    result_nxt = data_result;
    amt_nxt    = amt;
    op_nxt     = op;
    stage_nxt  = stage;
    unique case (state)
      IDLE: begin
        if (ctrl_shift) begin
          result_nxt = data_operandA;
          amt_nxt    = ctrl_shiftamt;
          op_nxt     = ctrl_op;
          stage_nxt  = '0;
          state_nxt  = start_done ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        result_nxt = stage_out;
        if (finish_shift) state_nxt = DONE;
        else              stage_nxt = stage + STG_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      data_result <= '0;
      amt         <= '0;
      op          <= OP_SLL;
      stage       <= '0;
    end else begin
      state       <= state_nxt;
      data_result <= result_nxt;
      amt         <= amt_nxt;
      op          <= op_nxt;
      stage       <= stage_nxt;
    end
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Self-checking bench for iter_shift_ctrl: directed vectors, randomized ops against
// an arithmetic model, busy-ignore, back-to-back spacing and mid-operation reset.
module tb_iter_shift_ctrl;
  import shift_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_shift;
  logic [31:0]  data_operandA;
  logic [4:0]   ctrl_shiftamt;
  logic         ctrl_op;
  logic [31:0]  data_result;
  logic         data_resultRDY;
  logic         busy;

  int passed = 0;
  int total  = 0;

  iter_shift_ctrl #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .ctrl_op        (ctrl_op),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [4:0] amt,
                                               input logic op);
    logic signed [31:0] s;
    logic signed [31:0] r;
    s = a;
    r = s >>> amt;
    return op ? 32'(r) : (a << amt);
  endfunction

  // Cycles from the accept edge to the edge after which RDY is high.
  function automatic int model_latency(input logic [4:0] amt);
`ifdef ITER_SHIFT_EARLY_EXIT_EN
    for (int i = 0; i < SHAMT_W; i++) if (amt[i]) return SHAMT_W - i;
    return 0;
`else
    return NSTAGE;
`endif
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Runs one operation from IDLE and leaves the bench in the following IDLE cycle.
  task automatic do_op(input logic [31:0] a, input logic [4:0] amt, input logic op,
                       output logic [31:0] res, output int lat, output bit busy_ok,
                       output bit single);
    data_operandA = a;
    ctrl_shiftamt = amt;
    ctrl_op       = op;
    ctrl_shift    = 1'b1;
    step();
    ctrl_shift    = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!data_resultRDY && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    res = data_result;
    step();
    single = !data_resultRDY && !busy;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    total++;
    if (data_result !== 32'h0) $display("FAIL reset_result: got %h want %h", data_result, 32'h0);
    else passed++;
    total++;
    if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy: got %b want 0", data_resultRDY);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_directed;
    logic [31:0] va [7] = '{32'h0000FFFF, 32'h80000000, 32'h40000000, 32'h00000001,
                            32'h12345678, 32'h00000001, 32'h80000000};
    logic [4:0]  vs [7] = '{5'd16, 5'd4, 5'd31, 5'd31, 5'd0, 5'd3, 5'd31};
    logic        vo [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ve [7] = '{32'hFFFF0000, 32'hF8000000, 32'h00000000, 32'h80000000,
                            32'h12345678, 32'h00000008, 32'hFFFFFFFF};
    logic [31:0] res;
    int lat;
    bit busy_ok, single;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vs[i], vo[i], res, lat, busy_ok, single);
      total++;
      if (res !== ve[i]) $display("FAIL dir%0d_value: got %h want %h", i, res, ve[i]);
      else passed++;
      total++;
      if (lat != model_latency(vs[i]))
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, model_latency(vs[i]));
      else passed++;
      total++;
      if (!busy_ok || !single)
        $display("FAIL dir%0d_busy_pulse: got busy_ok=%0d single=%0d want 1/1", i, busy_ok, single);
      else passed++;
      total++;
      if (data_result !== ve[i]) $display("FAIL dir%0d_hold: got %h want %h", i, data_result, ve[i]);
      else passed++;
    end
  endtask

  task automatic test_random;
    logic [31:0] a, res;
    logic [4:0]  amt;
    logic        op;
    int lat;
    bit busy_ok, single;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      amt = 5'($urandom_range(0, 31));
      op  = 1'($urandom_range(0, 1));
      do_op(a, amt, op, res, lat, busy_ok, single);
      total++;
      if (res !== model_result(a, amt, op))
        $display("FAIL rnd%0d_value: a=%h amt=%0d op=%0d got %h want %h",
                 i, a, amt, op, res, model_result(a, amt, op));
      else passed++;
      total++;
      if (lat != model_latency(amt) || !busy_ok || !single)
        $display("FAIL rnd%0d_timing: got lat=%0d busy_ok=%0d single=%0d want lat=%0d",
                 i, lat, busy_ok, single, model_latency(amt));
      else passed++;
    end
  endtask

  // A start request held from A+2 onward must be ignored while busy and only
  // accepted in the IDLE cycle after DONE, giving a 7-cycle RDY spacing.
  task automatic test_back_to_back;
    logic [31:0] a1, a2, res1;
    int cyc, gap;
    a1 = 32'hA5A50F0F;
    a2 = $urandom | 32'h80000000;
    data_operandA = a1;
    ctrl_shiftamt = 5'd1;
    ctrl_op       = OP_SLL;
    ctrl_shift    = 1'b1;
    step();
    ctrl_shift = 1'b0;
    cyc = 0;
    while (!data_resultRDY && cyc < 20) begin
      step();
      cyc++;
      if (cyc == 1) begin
        data_operandA = a2;
        ctrl_shiftamt = 5'd1;
        ctrl_op       = OP_SRA;
        ctrl_shift    = 1'b1;
      end
    end
    res1 = data_result;
    total++;
    if (cyc != model_latency(5'd1) || res1 !== model_result(a1, 5'd1, OP_SLL))
      $display("FAIL busy_ignore_first: got lat=%0d val=%h want lat=%0d val=%h",
               cyc, res1, model_latency(5'd1), model_result(a1, 5'd1, OP_SLL));
    else passed++;
    step();
    gap = 1;
    total++;
    if (busy !== 1'b0) $display("FAIL busy_not_queued: got busy=%b want 0", busy);
    else passed++;
    step();
    gap++;
    ctrl_shift = 1'b0;
    while (!data_resultRDY && gap < 30) begin
      step();
      gap++;
    end
    total++;
    if (gap != 7) $display("FAIL b2b_spacing: got %0d want 7", gap);
    else passed++;
    total++;
    if (data_result !== model_result(a2, 5'd1, OP_SRA))
      $display("FAIL b2b_value: got %h want %h", data_result, model_result(a2, 5'd1, OP_SRA));
    else passed++;
    step();
  endtask

  task automatic test_reset_midop;
    logic [31:0] res;
    int lat;
    bit busy_ok, single, saw_rdy;
    data_operandA = 32'hDEADBEEF;
    ctrl_shiftamt = 5'd31;
    ctrl_op       = OP_SRA;
    ctrl_shift    = 1'b1;
    step();
    ctrl_shift = 1'b0;
    step();
    reset = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || data_result !== 32'h0 || data_resultRDY !== 1'b0)
      $display("FAIL midop_reset: got busy=%b result=%h rdy=%b want 0/00000000/0",
               busy, data_result, data_resultRDY);
    else passed++;
    reset   = 1'b0;
    saw_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (data_resultRDY) saw_rdy = 1'b1;
      step();
    end
    total++;
    if (saw_rdy) $display("FAIL midop_no_pulse: got rdy pulse want none");
    else passed++;
    do_op(32'h0F000000, 5'd4, OP_SLL, res, lat, busy_ok, single);
    total++;
    if (res !== 32'hF0000000 || lat != model_latency(5'd4) || !busy_ok || !single)
      $display("FAIL midop_restart: got %h lat=%0d want %h lat=%0d",
               res, lat, 32'hF0000000, model_latency(5'd4));
    else passed++;
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_shift    = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    ctrl_op       = OP_SLL;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
